// File: rtl/ser_pkg.sv
// Shared types and line-level constants for the ser_tx / serdes serial link.
package ser_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } ser_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_tx_two_phase_ack.sv
// Two-phase acknowledge register: ack toggles once per accept strobe,
// and a request is pending whenever req and ack differ.
module two_phase_ack (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic accept,
   output logic ack,
   output logic pending
);

   logic r_ack;

   always_ff @(posedge clk) begin
      if (rst)
         r_ack <= 1'b0;
      else if (accept)
         r_ack <= ~r_ack;
   end

   assign ack     = r_ack;
   assign pending = req ^ r_ack;

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial framer: start bit, data LSB first, optional even parity,
// stop bit. Parity is compiled in with SER_TX_PARITY_EN.
module ser_tx
   import ser_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  req,
   output logic                  ack,
   output logic                  dout,
   output logic                  busy
);

   localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   ser_state_t            r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
   logic [CW-1:0]         r_cnt,   w_cnt_nxt;
   logic                  r_dout,  w_dout_nxt;
   logic                  r_busy,  w_busy_nxt;
   logic                  w_accept;
   logic                  w_pending;
`ifdef SER_TX_PARITY_EN
   logic                  r_par,   w_par_nxt;
`endif

   two_phase_ack u_ack (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .accept  (w_accept),
      .ack     (ack),
      .pending (w_pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_dout  <= LINE_IDLE;
         r_busy  <= 1'b0;
`ifdef SER_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_busy  <= w_busy_nxt;
`ifdef SER_TX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_busy_nxt  = r_busy;
      w_accept    = 1'b0;
`ifdef SER_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         // The stop bit ends the same way idle does, giving gapless back-to-back frames.
         S_IDLE, S_STOP: begin
            if (w_pending) begin
               w_accept    = 1'b1;
               w_shift_nxt = data;
               w_cnt_nxt   = '0;
               w_dout_nxt  = START_BIT;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_START;
`ifdef SER_TX_PARITY_EN
               w_par_nxt   = ^data;
`endif
            end else begin
               w_dout_nxt  = LINE_IDLE;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         S_START: begin
            w_dout_nxt  = r_shift[0];
            w_shift_nxt = r_shift >> 1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (r_cnt == LAST) begin
`ifdef SER_TX_PARITY_EN
               w_dout_nxt  = r_par;
               w_state_nxt = S_PARITY;
`else
               w_dout_nxt  = STOP_BIT;
               w_state_nxt = S_STOP;
`endif
            end else begin
               w_dout_nxt  = r_shift[0];
               w_shift_nxt = r_shift >> 1;
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
`ifdef SER_TX_PARITY_EN
         S_PARITY: begin
            w_dout_nxt  = STOP_BIT;
            w_state_nxt = S_STOP;
         end
`endif
         default: begin
            w_dout_nxt  = LINE_IDLE;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign dout = r_dout;
   assign busy = r_busy;

endmodule
